// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan scheduler.
package disp_pkg;

  localparam int unsigned NUM_DIG   = 6;
  localparam int unsigned NUM_SEG   = 7;
  localparam logic [3:0]  BCD_BLANK = 4'hF;

  // Encodings are one-hot so the state register doubles as the grant output.
  typedef enum logic [2:0] {
    G_CLK = 3'b001,
    G_TMR = 3'b010,
    G_CHR = 3'b100
  } grant_e;

  // Active-high patterns {g,f,e,d,c,b,a}, indexed by BCD value 0..9.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] frame_digit(input logic [23:0] frame, input logic [2:0] idx);
    logic [3:0] d;
    unique case (idx)
      3'd0:    d = frame[3:0];
      3'd1:    d = frame[7:4];
      3'd2:    d = frame[11:8];
      3'd3:    d = frame[15:12];
      3'd4:    d = frame[19:16];
      3'd5:    d = frame[23:20];
      default: d = BCD_BLANK;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_lut.sv
// Combinational BCD to 7-segment decoder; codes 10..15 decode to all segments off.
module seg_lut
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = '0;
    if (bcd_i <= 4'd9) begin
      seg_o = SEG_LUT[bcd_i];
    end
  end

endmodule

// File: rtl/disp_scan_sched.sv
// Shares one serial 7-segment output between clock, timer and stopwatch sources.
// Optional leading-zero blanking of the two top digits: define DISP_SCAN_SCHED_LZB_EN.
module disp_scan_sched
  import disp_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 5000,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] clk_frame,
  input  logic        tmr_req,
  input  logic [23:0] tmr_frame,
  input  logic        chr_req,
  input  logic [23:0] chr_frame,
  input  logic        seg_pol,
  output logic        seg_bit,
  output logic [2:0]  seg_idx,
  output logic [2:0]  dig_idx,
  output logic [2:0]  gnt,
  output logic        frame_start
);

  localparam int unsigned CntW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);
  localparam logic [2:0]       SegLast = 3'(NUM_SEG - 1);
  localparam logic [2:0]       DigLast = 3'(NUM_DIG - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       seg_q, seg_d;
  logic [2:0]       dig_q, dig_d;
  grant_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [23:0]      snap_q, snap_d;
  logic             seg_on_q, seg_on_d;
  logic             pol_q, pol_d;
  logic             pol_vld_q, pol_vld_d;
  logic             fs_q, fs_d;

  logic        tick;
  logic        boundary;
  logic [23:0] sel_frame;
  logic [23:0] load_frame;
  logic [3:0]  cur_digit;
  logic [6:0]  pat;
  logic [7:0]  pat8;

  assign tick     = (cnt_q == CntMax);
  assign boundary = tick && (seg_q == SegLast) && (dig_q == DigLast);

  // Tick divider and scan position.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    seg_d = seg_q;
    dig_d = dig_q;
    if (tick) begin
      cnt_d = '0;
      if (seg_q == SegLast) begin
        seg_d = '0;
        dig_d = (dig_q == DigLast) ? 3'd0 : dig_q + 3'd1;
      end else begin
        seg_d = seg_q + 3'd1;
      end
    end
  end

  // Ownership arbitration, evaluated only at frame boundaries.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (boundary) begin
      unique case (state_q)
        G_CLK: begin
          if (tmr_req) begin
            state_d = G_TMR;
          end else if (chr_req) begin
            state_d = G_CHR;
          end
        end
        G_TMR: begin
          if (!tmr_req) begin
            state_d = chr_req ? G_CHR : G_CLK;
          end else if (hold_q < HoldMax) begin
            hold_d = hold_q + 1'b1;
          end
        end
        G_CHR: begin
          if (!chr_req) begin
            state_d = tmr_req ? G_TMR : G_CLK;
          end else if (hold_q < HoldMax) begin
            hold_d = hold_q + 1'b1;
          end else if (tmr_req) begin
            state_d = G_TMR;
          end
        end
        default: state_d = G_CLK;
      endcase
      if (state_d != state_q) begin
        hold_d = '0;
      end
    end
  end

  // The snapshot follows the owner chosen at this same boundary.
  always_comb begin
    unique case (state_d)
      G_TMR:   sel_frame = tmr_frame;
      G_CHR:   sel_frame = chr_frame;
      default: sel_frame = clk_frame;
    endcase
    load_frame = sel_frame;
`ifdef DISP_SCAN_SCHED_LZB_EN
    if (sel_frame[23:20] == 4'd0) begin
      load_frame[23:20] = BCD_BLANK;
      if (sel_frame[19:16] == 4'd0) begin
        load_frame[19:16] = BCD_BLANK;
      end
    end
`endif
    snap_d = boundary ? load_frame : snap_q;
  end

  // Decode from next-state values so the level lines up with the new indices.
  assign cur_digit = frame_digit(snap_d, dig_d);

  seg_lut u_seg_lut (
    .bcd_i (cur_digit),
    .seg_o (pat)
  );

  assign pat8 = {1'b0, pat};

  always_comb begin
    seg_on_d  = tick ? pat8[seg_d] : seg_on_q;
    pol_d     = tick ? seg_pol : pol_q;
    pol_vld_d = pol_vld_q | tick;
    fs_d      = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      seg_q     <= '0;
      dig_q     <= '0;
      state_q   <= G_CLK;
      hold_q    <= '0;
      snap_q    <= {NUM_DIG{BCD_BLANK}};
      seg_on_q  <= 1'b0;
      pol_q     <= 1'b0;
      pol_vld_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      snap_q    <= snap_d;
      seg_on_q  <= seg_on_d;
      pol_q     <= pol_d;
      pol_vld_q <= pol_vld_d;
      fs_q      <= fs_d;
    end
  end

  // Until the first tick after reset the blank level tracks the live polarity.
  assign seg_bit     = seg_on_q ^ (pol_vld_q ? pol_q : seg_pol);
  assign seg_idx     = seg_q;
  assign dig_idx     = dig_q;
  assign gnt         = state_q;
  assign frame_start = fs_q;

endmodule
